count_ctrl: RTL and testbench
=============================

# count_ctrl

Run/pause/clear controller for the LED display counter. Consumes the tick period `tm_value` and `count_en` produced by `sw_mode`, divides `clk` down to a one-cycle `tick` every `tm_value` cycles while running, and advances a DIGITS-wide BCD counter that feeds the seven-segment scan logic. It is the only block that sequences when the display count moves.

## Interface
- CNT_W, 27: width of `tm_value` and the internal prescaler.
- DIGITS, 4: number of BCD digits in `digits`.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tm_value  in  CNT_W  tick period in `clk` cycles, from `sw_mode`; 0 is treated as 1.
- count_en  in  1  prescaler enable from `sw_mode`.
- btn_start  in  1  synchronous single-cycle pulse, already debounced; toggles run/pause.
- clr  in  1  synchronous single-cycle pulse; returns to IDLE and zeroes the count.
- tick  out  1  one-cycle pulse on each count advance.
- digits  out  4*DIGITS  BCD count; digit 0 is in bits [3:0] and is the least significant.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
- ovf  out  1  one-cycle pulse when the count passes all-9s.

## Operation
- Reset (`rst` = 0): state IDLE, prescaler 0, `digits` 0, `tick` 0, `ovf` 0. All outputs are registered.
- FSM transitions, evaluated per edge:
  - `clr` = 1 → IDLE from any state. `clr` has priority over `btn_start` in the same cycle.
  - IDLE + `btn_start` → RUN.
  - RUN + `btn_start` → PAUSE.
  - PAUSE + `btn_start` → RUN.
  - Otherwise the state holds.
- Entering IDLE zeroes the prescaler and `digits`. Entering PAUSE freezes both at their current values.
- Prescaler behaviour:
  - Advances only when state is RUN, `count_en` = 1 and `clr` = 0.
  - Terminal condition: prescaler ≥ max(`tm_value`,1) − 1. On terminal the prescaler returns to 0 and `tick` is pulsed; otherwise it increments.
  - The ≥ compare matters when `tm_value` shrinks mid-period: the next enabled cycle fires `tick` immediately rather than overrunning.
- RUN with `count_en` = 0: the prescaler holds (it is not cleared), no `tick`, state stays RUN.
- Counter update:
  - Increments in BCD on the same edge that raises `tick`, so `digits` and `tick` update together.
  - Each digit wraps 9→0 with a carry into the next digit.
- All-9s + tick: behaviour depends on COUNT_CTRL_SAT_EN (see Configuration). `ovf` is high for that one cycle only.
- A `btn_start` that arrives on the same edge as a terminal prescaler: if it takes the FSM from RUN to PAUSE, the tick still fires and the count still advances on that edge; the FSM enters PAUSE afterwards.

## Timing
- Registered start: `btn_start` sampled at edge N sets state = RUN from edge N, with the prescaler at 0.
- With constant T = max(`tm_value`,1) and `count_en` = 1, the first `tick` goes high after edge N+T. Ticks then repeat every T cycles.
- T = 1: `tick` is high every cycle, starting at edge N+1.
- Pause/resume: pausing with the prescaler at p and resuming at edge M gives the next tick at edge M + (T − p). The partial period is preserved.
- `clr`: outputs read IDLE / 0 at the next edge. The `tick` and `ovf` pulses are suppressed on that edge.
- Asynchronous reset mid-count: outputs return to reset values immediately, independent of `clk`.

## Configuration
- COUNT_CTRL_SAT_EN defined (saturating mode):
  - On tick at all-9s, `digits` stays at all-9s.
  - `ovf` pulses.
  - FSM moves to PAUSE on the same edge.
  - A subsequent `btn_start` resumes to RUN, but the count stays saturated until `clr`.
- COUNT_CTRL_SAT_EN undefined (wrapping mode):
  - On tick at all-9s, `digits` wraps to 0.
  - `ovf` pulses.
  - State stays RUN.

## Test plan
- Reset then idle: `rst` = 0 for 2 cycles, then 1, with `tm_value` = 4 and no buttons → `state` = 00, `digits` = 0x0000, `tick` never asserted.
- Basic run: `tm_value` = 4, `count_en` = 1, `btn_start` pulse at edge N → `tick` at N+4, N+8, N+12; `digits` = 0x0003 after N+12.
- Pause/resume and enable gating:
  - Pause at N+6 (prescaler = 2): no ticks while paused. Resume at M → next tick at M+2.
  - Hold `count_en` = 0 for 10 cycles in RUN → no ticks and the prescaler is preserved.
- Carry/overflow: preload by running with `tm_value` = 1 to 0x9999 → next tick gives `ovf` = 1.
  - Without COUNT_CTRL_SAT_EN: `digits` = 0x0000, `state` = 01.
  - With COUNT_CTRL_SAT_EN: `digits` = 0x9999, `state` = 10.
- Period change: running with `tm_value` = 8 and prescaler = 5, switch `tm_value` to 3 → tick on the next enabled edge, then every 3 cycles.
- Priority and reset: `clr` and `btn_start` in the same cycle while in RUN → `state` = 00, `digits` = 0. `rst` dropped asynchronously mid-period → outputs zero before the next `clk` edge.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/clear sequencer with prescaler and BCD display counter.
// Latency: every output is registered; a sampled input changes the outputs one clk edge later.
// Backpressure: none; the block is driven by single-cycle pulses and never stalls its inputs.
//
// Optional feature: define COUNT_CTRL_SAT_EN for saturating mode. In that mode the count
// holds at all-9s and the FSM drops to PAUSE when it overflows. Without the macro, the
// count wraps to zero and the FSM stays in RUN.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   tm_value   tick period in clk cycles; 0 behaves as 1
//   count_en   prescaler enable
//   btn_start  debounced single-cycle pulse; toggles run/pause (starts from IDLE)
//   clr        single-cycle pulse; back to IDLE with the count zeroed (beats btn_start)
//   tick       one-cycle pulse on each count advance
//   digits     BCD count; digit 0 in [3:0] is the least significant
//   state      00 IDLE, 01 RUN, 10 PAUSE
//   ovf        one-cycle pulse when the count passes all-9s

module count_ctrl #(
  parameter int CNT_W  = 27,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      tm_value,
  input  logic                  count_en,
  input  logic                  btn_start,
  input  logic                  clr,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   digits,
  output logic [1:0]            state,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]    PRESC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      presc_q, presc_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic                  tick_q, tick_d;
  logic                  ovf_q, ovf_d;

  logic [CNT_W-1:0]      tm_eff;
  logic [CNT_W-1:0]      term_lim;
  logic                  presc_adv;
  logic                  presc_term;
  logic                  fire;
  logic                  at_max;
  logic [4*DIGITS-1:0]   digits_inc;

  // Ripple BCD increment: each nibble wraps 9->0 and carries into the next one.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (d[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A period of 0 would never terminate; treat it as 1 so the tick fires every cycle.
  assign tm_eff   = (tm_value == '0) ? PRESC_ONE : tm_value;
  assign term_lim = tm_eff - PRESC_ONE;

  // >= rather than == so that shrinking tm_value mid-period fires on the next
  // enabled cycle instead of running the prescaler past the new limit.
  assign presc_term = (presc_q >= term_lim);
  assign presc_adv  = (state_q == RUN) && count_en && !clr;
  assign fire       = presc_adv && presc_term;

  assign at_max     = (digits_q == ALL_NINES);
  assign digits_inc = bcd_inc(digits_q);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (btn_start) state_d = RUN;
        RUN:     if (btn_start) state_d = PAUSE;
        PAUSE:   if (btn_start) state_d = RUN;
        default: state_d = IDLE;
      endcase
`ifdef COUNT_CTRL_SAT_EN
      // Overflow in saturating mode parks the FSM in PAUSE regardless of btn_start.
      if (fire && at_max) begin
        state_d = PAUSE;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, counter and pulse outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    ovf_d    = 1'b0;

    if (clr || (state_q == IDLE)) begin
      // IDLE keeps everything at zero so a start always begins a full period.
      presc_d  = '0;
      digits_d = '0;
    end else if (presc_adv) begin
      if (presc_term) begin
        presc_d = '0;
        tick_d  = 1'b1;
        ovf_d   = at_max;
        if (at_max) begin
`ifdef COUNT_CTRL_SAT_EN
          digits_d = digits_q;
`else
          digits_d = '0;
`endif
        end else begin
          digits_d = digits_inc;
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
    // PAUSE, or RUN with count_en low: prescaler and digits hold their values.
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tick   = tick_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;
  assign state  = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed stimulus with a tick scoreboard for count_ctrl.
// Stimulus pushes the expected edge number, digits, state and ovf for every tick.
// A negedge monitor pops one entry per observed tick and compares it.

module tb_count_ctrl;

  localparam int CNT_W  = 27;
  localparam int DIGITS = 4;

  logic                clk;
  logic                rst;
  logic [CNT_W-1:0]    tm_value;
  logic                count_en;
  logic                btn_start;
  logic                clr;
  logic                tick;
  logic [4*DIGITS-1:0] digits;
  logic [1:0]          state;
  logic                ovf;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [1:0]  st;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  count_ctrl #(.CNT_W(CNT_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tm_value  (tm_value),
    .count_en  (count_en),
    .btn_start (btn_start),
    .clr       (clr),
    .tick      (tick),
    .digits    (digits),
    .state     (state),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; at a negedge it names the edge just taken.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic expect_tick(input int c, input int val, input logic [1:0] st, input logic o);
    exp_t e;
    e.cyc = c;
    e.dig = to_bcd(val);
    e.st  = st;
    e.ovf = o;
    sbq.push_back(e);
  endtask

  // Monitor: every observed tick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (tick) begin
        if (sbq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_tick: got tick at edge %0d expected none, digits %0h", cyc, digits);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("tick_edge",   32'(cyc),    32'(e.cyc));
          chk("tick_digits", 32'(digits), 32'(e.dig));
          chk("tick_state",  32'(state),  32'(e.st));
          chk("tick_ovf",    32'(ovf),    32'(e.ovf));
        end
      end else if (ovf) begin
        total_cnt++;
        $display("FAIL ovf_without_tick: got ovf=1 tick=0 expected ovf=0 at edge %0d", cyc);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(output int n);
    btn_start = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    rst       = 1'b0;
    tm_value  = 27'd4;
    count_en  = 1'b1;
    btn_start = 1'b0;
    clr       = 1'b0;

    // Reset and idle
    cycles(2);
    chk("reset_state",  32'(state),  32'(S_IDLE));
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_tick",   32'(tick),   32'h0);
    chk("reset_ovf",    32'(ovf),    32'h0);
    rst = 1'b1;
    cycles(6);
    chk("idle_state",  32'(state),  32'(S_IDLE));
    chk("idle_digits", 32'(digits), 32'h0);

    // Basic run, T = 4
    start(n);
    chk("start_state", 32'(state), 32'(S_RUN));
    expect_tick(n + 4,  1, S_RUN, 1'b0);
    expect_tick(n + 8,  2, S_RUN, 1'b0);
    expect_tick(n + 12, 3, S_RUN, 1'b0);
    wait_until(n + 12);
    chk("run_digits", 32'(digits), 32'h0003);
    do_clr();
    chk("clr_state",  32'(state),  32'(S_IDLE));
    chk("clr_digits", 32'(digits), 32'h0);

    // Pause with prescaler at 2, resume, then hold count_en low for 10 cycles
    start(n);
    expect_tick(n + 4, 1, S_RUN, 1'b0);
    wait_until(n + 5);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    cycles(10);
    chk("pause_state",  32'(state),  32'(S_PAUSE));
    chk("pause_digits", 32'(digits), 32'h0001);
    start(m);
    expect_tick(m + 2, 2, S_RUN, 1'b0);
    wait_until(m + 3);
    count_en = 1'b0;
    cycles(10);
    chk("gated_state", 32'(state), 32'(S_RUN));
    count_en = 1'b1;
    expect_tick(m + 16, 3, S_RUN, 1'b0);
    wait_until(m + 16);
    chk("gated_digits", 32'(digits), 32'h0003);
    do_clr();

    // Period shrinks from 8 to 3 with prescaler at 5, then a pause on a terminal edge
    tm_value = 27'd8;
    start(n);
    wait_until(n + 5);
    tm_value = 27'd3;
    expect_tick(n + 6,  1, S_RUN, 1'b0);
    expect_tick(n + 9,  2, S_RUN, 1'b0);
    expect_tick(n + 12, 3, S_RUN, 1'b0);
    wait_until(n + 14);
    btn_start = 1'b1;
    expect_tick(n + 15, 4, S_PAUSE, 1'b0);
    @(negedge clk);
    btn_start = 1'b0;
    cycles(4);
    chk("edge_pause_digits", 32'(digits), 32'h0004);
    do_clr();

    // clr and btn_start together while RUN, on an edge that would otherwise tick
    tm_value = 27'd2;
    start(n);
    expect_tick(n + 2, 1, S_RUN, 1'b0);
    wait_until(n + 3);
    clr       = 1'b1;
    btn_start = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    btn_start = 1'b0;
    chk("prio_state",  32'(state),  32'(S_IDLE));
    chk("prio_digits", 32'(digits), 32'h0);
    chk("prio_tick",   32'(tick),   32'h0);

    // Count to 9999 with T = 1, then overflow (tm_value 0 behaves as 1)
    tm_value = 27'd0;
    start(n);
    for (int k = 1; k <= 9999; k++) expect_tick(n + k, k, S_RUN, 1'b0);
`ifdef COUNT_CTRL_SAT_EN
    expect_tick(n + 10000, 9999, S_PAUSE, 1'b1);
    wait_until(n + 10000);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    expect_tick(n + 10002, 9999, S_PAUSE, 1'b1);
    wait_until(n + 10002);
    chk("sat_digits", 32'(digits), 32'h9999);
    chk("sat_state",  32'(state),  32'(S_PAUSE));
`else
    expect_tick(n + 10000, 0, S_RUN, 1'b1);
    expect_tick(n + 10001, 1, S_RUN, 1'b0);
    wait_until(n + 10001);
    chk("wrap_digits", 32'(digits), 32'h0001);
    chk("wrap_state",  32'(state),  32'(S_RUN));
`endif
    do_clr();

    // Asynchronous reset in the middle of a period
    tm_value = 27'd4;
    start(n);
    expect_tick(n + 4, 1, S_RUN, 1'b0);
    wait_until(n + 5);
    chk("pre_areset_digits", 32'(digits), 32'h0001);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_state",  32'(state),  32'(S_IDLE));
    chk("areset_digits", 32'(digits), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);

    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
